// File: rtl/sm4_arbiter.sv
// Round-robin arbiter sharing one sm4top core between two requesters.
// One operation in flight at a time, guarded by a watchdog in WAIT.
module sm4_arbiter #(
  parameter int unsigned DATAWIDTH = 128,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TMRW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_isdec,
  input  logic [DATAWIDTH-1:0] req0_key,
  input  logic [DATAWIDTH-1:0] req0_data,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [DATAWIDTH-1:0] rsp0_data,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_isdec,
  input  logic [DATAWIDTH-1:0] req1_key,
  input  logic [DATAWIDTH-1:0] req1_data,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [DATAWIDTH-1:0] rsp1_data,
  output logic                 rsp1_err,
  output logic                 core_isdec,
  output logic                 core_start_input,
  output logic                 core_end_input,
  output logic [DATAWIDTH-1:0] core_datain,
  output logic [DATAWIDTH-1:0] core_mkin,
  input  logic [DATAWIDTH-1:0] core_dataout,
  input  logic                 core_valid,
  output logic                 busy,
  output logic                 grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [TMRW-1:0] TimerLast = TMRW'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   grant_q, grant_d;
  logic [TMRW-1:0]        timer_q, timer_d;
  logic                   op_isdec_q, op_isdec_d;
  logic [DATAWIDTH-1:0]   op_key_q, op_key_d;
  logic [DATAWIDTH-1:0]   op_data_q, op_data_d;
  logic [DATAWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  // Next-state logic and all combinational outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    op_isdec_d = op_isdec_q;
    op_key_d   = op_key_q;
    op_data_d  = op_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    core_start_input = 1'b0;
    core_end_input   = 1'b0;
    core_isdec       = 1'b0;
    core_datain      = '0;
    core_mkin        = '0;
    rsp0_valid       = 1'b0;
    rsp0_data        = '0;
    rsp0_err         = 1'b0;
    rsp1_valid       = 1'b0;
    rsp1_data        = '0;
    rsp1_err         = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ptr names the requester that wins a tie.
        req0_ready = req0_valid & (~ptr_q | ~req1_valid);
        req1_ready = req1_valid & (ptr_q | ~req0_valid);
        if (req0_ready) begin
          op_isdec_d = req0_isdec;
          op_key_d   = req0_key;
          op_data_d  = req0_data;
          grant_d    = 1'b0;
          ptr_d      = 1'b1;
          state_d    = StIssue;
        end else if (req1_ready) begin
          op_isdec_d = req1_isdec;
          op_key_d   = req1_key;
          op_data_d  = req1_data;
          grant_d    = 1'b1;
          ptr_d      = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        core_start_input = 1'b1;
        core_isdec       = op_isdec_q;
        core_datain      = op_data_q;
        core_mkin        = op_key_q;
        timer_d          = '0;
        state_d          = StWait;
      end
      StWait: begin
        // Timer is zero only in the first WAIT cycle; it cannot wrap before timeout.
        core_end_input = (timer_q == '0);
        core_isdec     = op_isdec_q;
        core_datain    = op_data_q;
        core_mkin      = op_key_q;
        timer_d        = timer_q + TMRW'(1);
        if (core_valid) begin
          rsp_data_d = core_dataout;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else if (timer_q == TimerLast) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (grant_q) begin
          rsp1_valid = 1'b1;
          rsp1_data  = rsp_data_q;
          rsp1_err   = rsp_err_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = rsp_data_q;
          rsp0_err   = rsp_err_q;
        end
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and operand registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      grant_q    <= 1'b0;
      timer_q    <= '0;
      op_isdec_q <= 1'b0;
      op_key_q   <= '0;
      op_data_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
      op_isdec_q <= op_isdec_d;
      op_key_q   <= op_key_d;
      op_data_q  <= op_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_sm4_arbiter.sv
// Scoreboard bench for sm4_arbiter with a behavioural stand-in for sm4top.
module tb_sm4_arbiter;

  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk, rst;
  logic         req0_valid, req0_ready, req0_isdec;
  logic [127:0] req0_key, req0_data;
  logic         rsp0_valid, rsp0_ready, rsp0_err;
  logic [127:0] rsp0_data;
  logic         req1_valid, req1_ready, req1_isdec;
  logic [127:0] req1_key, req1_data;
  logic         rsp1_valid, rsp1_ready, rsp1_err;
  logic [127:0] rsp1_data;
  logic         core_isdec, core_start_input, core_end_input, core_valid;
  logic [127:0] core_datain, core_mkin, core_dataout;
  logic         busy, grant_id;

  typedef struct {
    logic         id;
    logic [127:0] data;
    logic         err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int failures = 0;

  sm4_arbiter #(.TIMEOUT(10), .TMRW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_isdec(req0_isdec),
    .req0_key(req0_key), .req0_data(req0_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_isdec(req1_isdec),
    .req1_key(req1_key), .req1_data(req1_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_err(rsp1_err),
    .core_isdec(core_isdec), .core_start_input(core_start_input),
    .core_end_input(core_end_input), .core_datain(core_datain), .core_mkin(core_mkin),
    .core_dataout(core_dataout), .core_valid(core_valid),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core: known SM4 vector, otherwise an arbitrary reversible mix.
  function automatic logic [127:0] core_model(input logic dec, input logic [127:0] k,
                                               input logic [127:0] d);
    if (!dec && k == KEY && d == PT) return CT;
    if (dec && k == KEY && d == CT) return PT;
    return d ^ k ^ {128{dec}};
  endfunction

  // Stub core: answers 3 cycles after end_input unless manual mode is selected.
  logic         stub_manual, stub_en, cv_stub, cv_man;
  logic [127:0] cd_stub, cd_man;
  int           stub_cnt;
  assign core_valid   = stub_manual ? cv_man : cv_stub;
  assign core_dataout = stub_manual ? cd_man : cd_stub;

  initial begin
    cv_stub = 1'b0; cd_stub = '0; stub_cnt = 0;
    forever begin
      @(posedge clk); #1;
      cv_stub = 1'b0;
      if (rst) stub_cnt = 0;
      else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) cv_stub = 1'b1;
      end else if (core_end_input && stub_en) begin
        cd_stub  = core_model(core_isdec, core_mkin, core_datain);
        stub_cnt = 3;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b want=0", grant_id); end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_start_input, core_end_input} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=0",
        {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_start_input, core_end_input});
    end
    checks++;
    if ({core_datain, core_mkin, rsp0_data, rsp1_data} !== '0) begin
      failures++; $display("FAIL reset_data got=nonzero want=0");
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_enc0();
    bit got;
    stub_manual = 1'b0; stub_en = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_isdec = 1'b0; req0_key = KEY; req0_data = PT;
    sb.push_back('{id: 1'b0, data: core_model(1'b0, KEY, PT), err: 1'b0});
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL enc0_ready got=%b want=1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checks++;
    if ({core_start_input, core_end_input} !== 2'b10) begin
      failures++; $display("FAIL enc0_start got=%b want=10", {core_start_input, core_end_input});
    end
    checks++; if (core_datain !== PT) begin failures++; $display("FAIL enc0_datain got=%h want=%h", core_datain, PT); end
    @(posedge clk); #1;
    checks++;
    if ({core_start_input, core_end_input} !== 2'b01) begin
      failures++; $display("FAIL enc0_end got=%b want=01", {core_start_input, core_end_input});
    end
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (rsp1_valid) begin failures++; checks++; $display("FAIL enc0_rsp1 got=1 want=0"); end
      if (rsp0_valid) got = 1;
    end
    checks++;
    if (!got || sb.size() == 0) begin
      failures++; $display("FAIL enc0_rsp got=none want=rsp0_valid");
    end else begin
      e = sb.pop_front();
      checks++; if (rsp0_data !== e.data) begin failures++; $display("FAIL enc0_data got=%h want=%h", rsp0_data, e.data); end
      checks++; if (rsp0_err !== e.err) begin failures++; $display("FAIL enc0_err got=%b want=%b", rsp0_err, e.err); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL enc0_idle busy=%b want=0", busy); end
  endtask

  task automatic test_dec1();
    bit got;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_isdec = 1'b1; req1_key = KEY; req1_data = CT;
    sb.push_back('{id: 1'b1, data: core_model(1'b1, KEY, CT), err: 1'b0});
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL dec1_ready got=%b want=1", req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    checks++; if (grant_id !== 1'b1) begin failures++; $display("FAIL dec1_grant got=%b want=1", grant_id); end
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (rsp0_valid) begin failures++; checks++; $display("FAIL dec1_rsp0 got=1 want=0"); end
      if (rsp1_valid) got = 1;
    end
    checks++;
    if (!got || sb.size() == 0) begin
      failures++; $display("FAIL dec1_rsp got=none want=rsp1_valid");
    end else begin
      e = sb.pop_front();
      checks++; if (rsp1_data !== e.data) begin failures++; $display("FAIL dec1_data got=%h want=%h", rsp1_data, e.data); end
      checks++; if (rsp1_err !== e.err) begin failures++; $display("FAIL dec1_err got=%b want=%b", rsp1_err, e.err); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    logic [127:0] d0 [4];
    logic [127:0] d1 [4];
    int n0, n1, got;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d0[k] = {32'hA0A0_0000 + k, 96'h1234_5678_9abc_def0_1111_2222};
      d1[k] = {32'hB1B1_0000 + k, 96'h0fed_cba9_8765_4321_3333_4444};
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{id: 1'b0, data: core_model(1'b0, KEY, d0[k]), err: 1'b0});
      sb.push_back('{id: 1'b1, data: core_model(1'b1, KEY, d1[k]), err: 1'b0});
    end
    n0 = 0; n1 = 0; got = 0;
    req0_isdec = 1'b0; req1_isdec = 1'b1; req0_key = KEY; req1_key = KEY;
    for (int c = 0; c < 400 && got < 8; c++) begin
      req0_valid = (n0 < 4); req0_data = (n0 < 4) ? d0[n0] : '0;
      req1_valid = (n1 < 4); req1_data = (n1 < 4) ? d1[n1] : '0;
      #1;
      if (req0_ready && req1_ready) begin
        failures++; checks++; $display("FAIL fair_both_ready got=11 want=one");
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL fair_sb_empty got=response want=none");
        end else begin
          e = sb.pop_front();
          if (rsp1_valid !== e.id || (e.id ? rsp1_data : rsp0_data) !== e.data) begin
            failures++;
            $display("FAIL fair_order got=id%0d/%h want=id%0d/%h", rsp1_valid,
                     rsp1_valid ? rsp1_data : rsp0_data, e.id, e.data);
          end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (got != 8) begin failures++; $display("FAIL fair_count got=%0d want=8", got); end
    checks++;
    if (n0 != 4 || n1 != 4) begin
      failures++; $display("FAIL fair_accepts got=%0d/%0d want=4/4", n0, n1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n;
    stub_manual = 1'b1; cv_man = 1'b0; cd_man = '0;
    req0_valid = 1'b1; req0_isdec = 1'b0; req0_key = KEY; req0_data = 128'hdead;
    sb.push_back('{id: 1'b0, data: '0, err: 1'b1});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (core_end_input !== 1'b1) begin failures++; $display("FAIL to_wait_entry got=%b want=1", core_end_input); end
    n = 0;
    for (int c = 1; c <= 30 && n == 0; c++) begin
      @(posedge clk); #1;
      if (rsp0_valid) n = c;
    end
    checks++; if (n != 10) begin failures++; $display("FAIL to_latency got=%0d want=10", n); end
    if (n != 0 && sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (rsp0_data !== e.data) begin failures++; $display("FAIL to_data got=%h want=%h", rsp0_data, e.data); end
      checks++; if (rsp0_err !== e.err) begin failures++; $display("FAIL to_err got=%b want=%b", rsp0_err, e.err); end
    end
    repeat (3) @(posedge clk);
    #1;
    cv_man = 1'b1; cd_man = PT;
    @(posedge clk); #1;
    cv_man = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
        failures++; $display("FAIL to_late_valid got=%b want=000", {busy, rsp0_valid, rsp1_valid});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_valid_on_timeout();
    logic [127:0] v;
    v = 128'h5a5a_1234_0000_ffff_c3c3_8765_0101_abcd;
    stub_manual = 1'b1; cv_man = 1'b0;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 128'hbeef;
    sb.push_back('{id: 1'b0, data: v, err: 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (core_end_input !== 1'b1) begin failures++; $display("FAIL vt_wait_entry got=%b want=1", core_end_input); end
    repeat (9) @(posedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL vt_early got=%b want=0", rsp0_valid); end
    cv_man = 1'b1; cd_man = v;
    @(posedge clk); #1;
    cv_man = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL vt_rsp got=%b want=1", rsp0_valid);
    end else begin
      e = sb.pop_front();
      checks++; if (rsp0_data !== e.data) begin failures++; $display("FAIL vt_data got=%h want=%h", rsp0_data, e.data); end
      checks++; if (rsp0_err !== e.err) begin failures++; $display("FAIL vt_err got=%b want=%b", rsp0_err, e.err); end
    end
    req1_valid = 1'b1; req1_data = 128'h77;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== v || req1_ready !== 1'b0 || core_datain !== '0) begin
        failures++;
        $display("FAIL vt_hold got=v%b r1%b d=%h want=v1 r10 d=%h", rsp0_valid, req1_ready,
                 rsp0_data, v);
      end
    end
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      failures++; $display("FAIL vt_release got=%b want=00", {busy, rsp0_valid});
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    stub_manual = 1'b1; cv_man = 1'b0;
    req0_valid = 1'b1; req0_data = 128'h1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, grant_id, core_datain != '0} !== 3'b000) begin
      failures++; $display("FAIL rm_async got=%b want=000", {busy, grant_id, core_datain != '0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cv_man = 1'b1; cd_man = 128'h99;
    @(posedge clk); #1;
    cv_man = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
        failures++; $display("FAIL rm_no_rsp got=%b want=000", {busy, rsp0_valid, rsp1_valid});
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    sb.push_back('{id: 1'b0, data: '0, err: 1'b1});
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL rm_ptr got=%b want=10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL rm_grant got=%b want=0", grant_id); end
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge clk); #1;
      if (rsp0_valid) got = 1;
    end
    checks++;
    if (!got || sb.size() == 0) begin
      failures++; $display("FAIL rm_rsp got=none want=rsp0_valid");
    end else begin
      e = sb.pop_front();
      if (rsp0_err !== e.err || rsp0_data !== e.data) begin
        failures++; $display("FAIL rm_rsp_val got=%b/%h want=%b/%h", rsp0_err, rsp0_data, e.err, e.data);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_isdec = 1'b0; req0_key = '0; req0_data = '0;
    req1_valid = 1'b0; req1_isdec = 1'b0; req1_key = '0; req1_data = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    stub_manual = 1'b0; stub_en = 1'b1; cv_man = 1'b0; cd_man = '0;
    test_reset();
    test_enc0();
    test_dec1();
    test_fairness();
    test_timeout();
    test_valid_on_timeout();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm4_arbiter.md
Name: sm4_arbiter

Overview:
Shares one sm4top encryption/decryption core between two independent requesters. Each requester issues a 128-bit block plus key and a direction flag over a valid/ready channel. The arbiter grants requests round-robin, drives the core's start_input/end_input sequence, guards each operation with a watchdog, and routes the result back to the requester that was granted. It sits between the AXIS front-ends and the shared sm4top instance, with one operation in flight at a time.

Parameters:
DATAWIDTH, 128, block/key width; fixed by SM4, not to be overridden.
TIMEOUT, 64, maximum cycles in WAIT before an error response; legal range 2..255.
TMRW, 8, watchdog counter width; must satisfy 2^TMRW > TIMEOUT.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle when high together with req0_valid.
req0_isdec  in  1  1 = decrypt, 0 = encrypt.
req0_key  in  128  master key.
req0_data  in  128  input block.
rsp0_valid  out  1  response for requester 0 is valid.
rsp0_ready  in  1  requester 0 accepts the response.
rsp0_data  out  128  result block.
rsp0_err  out  1  watchdog expired; rsp0_data is 0.
req1_*, rsp1_*  same as requester 0.
core_isdec  out  1  to sm4top isdec.
core_start_input  out  1  to sm4top start_input.
core_end_input  out  1  to sm4top end_input.
core_datain  out  128  to sm4top datain.
core_mkin  out  128  to sm4top mkin.
core_dataout  in  128  from sm4top dataout.
core_valid  in  1  from sm4top valid.
busy  out  1  high in any state other than IDLE.
grant_id  out  1  requester currently owning the core; holds its last value in IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset: state=IDLE, ptr=0, grant_id=0, timer=0. All core_* outputs, rsp*_valid, rsp*_err and rsp*_data are 0.
- IDLE: req0_ready = req0_valid & (ptr==0 | !req1_valid). req1_ready = req1_valid & (ptr==1 | !req0_valid). Both ready signals are 0 outside IDLE. Requester valid must not depend on ready.
- On acceptance (cycle A): capture isdec/key/data into operand registers, set grant_id to the winner, set ptr to the other requester, go to ISSUE.
- ISSUE (A+1): core_start_input=1 for one cycle. Go to WAIT.
- WAIT: core_end_input=1 in the first WAIT cycle only (A+2). core_datain, core_mkin and core_isdec hold the captured operands from A+1 until WAIT exits, and are 0 in IDLE and RESP. The timer is cleared on WAIT entry and increments each cycle.
- WAIT, core_valid=1: capture core_dataout, set err=0, go to RESP. The response is visible on the cycle after core_valid.
- WAIT, timer==TIMEOUT-1 and core_valid=0: data=0, err=1, go to RESP. If core_valid and timeout occur in the same cycle, core_valid wins (err=0).
- core_valid outside WAIT is ignored. This includes a late result after a timeout.
- RESP: rspX_valid=1 only for X=grant_id; the other response port stays 0. rspX_data and rspX_err are held stable until rspX_ready. On the handshake, go to IDLE with outputs cleared. A new request can be accepted on the cycle after the handshake.
- A requester's request may stay valid while its response is pending. It is re-arbitrated in IDLE.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Reset asserted mid-operation: return immediately to reset values. Any in-flight result is dropped and no response is issued. The core is reset by the same rst at system level.

Test Plan:
- Req0 encrypt: key=data=0123456789abcdeffedcba9876543210, real core → start_input at A+1, end_input at A+2, rsp0_data=681edf34d206965e86b3e94f536e4246, rsp0_err=0, rsp1_valid stays 0.
- Req1 decrypt: key as above, data=681edf34d206965e86b3e94f536e4246 → rsp1_data=0123456789abcdeffedcba9876543210, grant_id=1.
- Both valid from reset, 4 operations each, rsp*_ready tied high → grant order 0,1,0,1,0,1,0,1; exactly one ready per acceptance.
- Stub core that never asserts valid, TIMEOUT=10 → error response exactly 10 cycles after WAIT entry, data=0, err=1. A core_valid injected 3 cycles later is ignored and busy=0.
- core_valid asserted on the timeout cycle → err=0, data=core_dataout. Then hold rsp0_ready=0 for 20 cycles → rsp0_valid and rsp0_data stable, req1_ready=0 throughout.
- rst pulsed in WAIT, then core_valid → no rsp*_valid, state IDLE, ptr=0, next simultaneous request granted to requester 0.
